dual_in_sigl_out_ram: RTL and testbench

Register-file style RAM with two independent write ports and one registered read port. The storage has a single physical write path, so port 1 has fixed priority. Port 2 writes that collide with port 1 are held in a small pending queue and drained on idle cycles. Reads see pending queued writes through forwarding, so queueing is invisible to the reader apart from port-2 backpressure.

---
 rtl/dual_in_sigl_out_ram.sv | 147 ++++++++++++++
 tb/tb_dual_in_sigl_out_ram.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_in_sigl_out_ram.sv
// Two-write-port, one-read-port register file. Port 1 always wins the single write path;
// colliding port-2 writes wait in a small FIFO that reads see through forwarding.
module dual_in_sigl_out_ram #(
    parameter int unsigned BW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned QD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en1,
    input  logic [AW-1:0] addr_in_1,
    input  logic [BW-1:0] data_in1,
    output logic          wr_ready1,
    input  logic          write_en2,
    input  logic [AW-1:0] addr_in_2,
    input  logic [BW-1:0] data_in2,
    output logic          wr_ready2,
    input  logic          read_en,
    input  logic [AW-1:0] addr_out,
    output logic [BW-1:0] data_out,
    output logic          data_valid
);

    localparam int unsigned PW = (QD > 1) ? $clog2(QD) : 1;
    localparam int unsigned CW = $clog2(QD + 1);
    localparam logic [CW-1:0] QD_CNT   = CW'(QD);
    localparam logic [PW-1:0] PTR_LAST = PW'(QD - 1);
    localparam logic [PW:0]   QD_WIDE  = (PW + 1)'(QD);

    logic [BW-1:0] r_mem [2**AW];

    logic [AW-1:0] r_q_addr [QD];
    logic [BW-1:0] r_q_data [QD];
    logic [QD-1:0] r_q_valid;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [BW-1:0] r_data_out;
    logic          r_data_valid;

    logic          w_rdy2;
    logic          w_acc2;
    logic          w_pop;
    logic          w_push;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [BW-1:0] w_wr_data;
    logic [BW-1:0] w_fwd_data;
    logic [PW:0]   w_idx_sum;
    logic [PW-1:0] w_idx;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_rdy2     = (r_count < QD_CNT);
    assign w_acc2     = write_en2 && w_rdy2;
    assign wr_ready1  = 1'b1;
    assign wr_ready2  = w_rdy2;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

    // Single storage write per edge: port 1, else queue head, else direct port 2.
    always_comb begin
        w_pop     = 1'b0;
        w_push    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = addr_in_1;
        w_wr_data = data_in1;
        if (write_en1) begin
            w_wr_en = 1'b1;
            w_push  = w_acc2;
        end else if (r_count != '0) begin
            w_pop     = 1'b1;
            w_push    = w_acc2;
            w_wr_en   = r_q_valid[r_head];
            w_wr_addr = r_q_addr[r_head];
            w_wr_data = r_q_data[r_head];
        end else if (w_acc2) begin
            w_wr_en   = 1'b1;
            w_wr_addr = addr_in_2;
            w_wr_data = data_in2;
        end
    end

    // Walk live entries oldest to youngest so the youngest valid match wins.
    always_comb begin
        w_fwd_data = r_mem[addr_out];
        w_idx_sum  = '0;
        w_idx      = '0;
        for (int i = 0; i < QD; i++) begin
            w_idx_sum = {1'b0, r_head} + (PW + 1)'(i);
            if (w_idx_sum >= QD_WIDE) begin
                w_idx_sum = w_idx_sum - QD_WIDE;
            end
            w_idx = w_idx_sum[PW-1:0];
            if ((CW'(i) < r_count) && r_q_valid[w_idx] && (r_q_addr[w_idx] == addr_out)) begin
                w_fwd_data = r_q_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_valid    <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            // A port-1 write supersedes anything already queued for that address.
            for (int i = 0; i < QD; i++) begin
                if (write_en1 && r_q_valid[i] && (r_q_addr[i] == addr_in_1)) begin
                    r_q_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_q_valid[r_head] <= 1'b0;
                r_head            <= f_ptr_inc(r_head);
            end
            if (w_push) begin
                r_q_addr[r_tail]  <= addr_in_2;
                r_q_data[r_tail]  <= data_in2;
                r_q_valid[r_tail] <= 1'b1;
                r_tail            <= f_ptr_inc(r_tail);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_data_valid <= read_en;
            if (read_en) begin
                r_data_out <= w_fwd_data;
            end
        end
    end

endmodule

// File: tb/tb_dual_in_sigl_out_ram.sv
// Bench for dual_in_sigl_out_ram: directed vector table plus randomized traffic,
// both checked against a queue-based reference model of the write/forward rules.
module tb_dual_in_sigl_out_ram;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned QD = 2;

    logic          clk;
    logic          rst;
    logic          write_en1;
    logic [AW-1:0] addr_in_1;
    logic [BW-1:0] data_in1;
    logic          wr_ready1;
    logic          write_en2;
    logic [AW-1:0] addr_in_2;
    logic [BW-1:0] data_in2;
    logic          wr_ready2;
    logic          read_en;
    logic [AW-1:0] addr_out;
    logic [BW-1:0] data_out;
    logic          data_valid;

    dual_in_sigl_out_ram #(.BW(BW), .AW(AW), .QD(QD)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en1 (write_en1),
        .addr_in_1 (addr_in_1),
        .data_in1  (data_in1),
        .wr_ready1 (wr_ready1),
        .write_en2 (write_en2),
        .addr_in_2 (addr_in_2),
        .data_in2  (data_in2),
        .wr_ready2 (wr_ready2),
        .read_en   (read_en),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .data_valid(data_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic          we1;
        logic [AW-1:0] a1;
        logic [BW-1:0] d1;
        logic          we2;
        logic [AW-1:0] a2;
        logic [BW-1:0] d2;
        logic          re;
        logic [AW-1:0] ar;
    } in_t;

    typedef struct {
        in_t           i;
        logic          exp_valid;
        logic [BW-1:0] exp_out;
        logic          exp_rdy2;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        bit            v;
    } qent_t;

    // Reference model state
    qent_t         mq[$];
    logic [BW-1:0] mmem [2**AW];
    logic [BW-1:0] m_out;
    logic          m_valid;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit w1, int a1, int d1, bit w2, int a2, int d2,
                                bit rd, int ar, bit ev, int eo, bit er);
        vec_t v;
        v.i.rst = r;
        v.i.we1 = w1;
        v.i.a1  = AW'(a1);
        v.i.d1  = BW'(d1);
        v.i.we2 = w2;
        v.i.a2  = AW'(a2);
        v.i.d2  = BW'(d2);
        v.i.re  = rd;
        v.i.ar  = AW'(ar);
        v.exp_valid = ev;
        v.exp_out   = BW'(eo);
        v.exp_rdy2  = er;
        return v;
    endfunction

    function automatic in_t idle_in();
        in_t v;
        v = '{rst: 1'b0, we1: 1'b0, a1: '0, d1: '0, we2: 1'b0, a2: '0, d2: '0,
              re: 1'b0, ar: '0};
        return v;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act,
                         input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge of the specified behaviour, applied to the model.
    task automatic model_edge(input in_t v);
        bit     acc2;
        qent_t  e;
        if (v.rst) begin
            mq.delete();
            m_out   = '0;
            m_valid = 1'b0;
            return;
        end
        acc2 = v.we2 && (mq.size() < QD);
        if (v.re) begin
            m_out = mmem[v.ar];
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].v && mq[k].a == v.ar) m_out = mq[k].d;
            end
        end
        m_valid = v.re;
        if (v.we1) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].a == v.a1) begin
                    e = mq[k];
                    e.v = 1'b0;
                    mq[k] = e;
                end
            end
            mmem[v.a1] = v.d1;
            if (acc2) mq.push_back('{a: v.a2, d: v.d2, v: 1'b1});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v) mmem[e.a] = e.d;
            if (acc2) mq.push_back('{a: v.a2, d: v.d2, v: 1'b1});
        end else if (acc2) begin
            mmem[v.a2] = v.d2;
        end
    endtask

    task automatic step(input in_t v, input string tag);
        rst       = v.rst;
        write_en1 = v.we1;
        addr_in_1 = v.a1;
        data_in1  = v.d1;
        write_en2 = v.we2;
        addr_in_2 = v.a2;
        data_in2  = v.d2;
        read_en   = v.re;
        addr_out  = v.ar;
        @(posedge clk);
        model_edge(v);
        #1;
        check({tag, " model data_valid"}, BW'(data_valid), BW'(m_valid));
        check({tag, " model data_out"}, data_out, m_out);
        check({tag, " model wr_ready2"}, BW'(wr_ready2), BW'(mq.size() < QD));
        check({tag, " wr_ready1"}, BW'(wr_ready1), BW'(1'b1));
    endtask

    initial begin
        in_t v;
        m_out   = '0;
        m_valid = 1'b0;

        // Directed vectors: inputs, then data_valid/data_out/wr_ready2 after the edge.
        tbl.push_back(mk(0, 1, 3, 'h11, 0, 0, 0,    0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 3, 1, 'h11,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 1, 1, 'hAA, 1, 2, 'hBB, 0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 2, 1, 'hBB,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 1, 1, 'hAA,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 2, 1, 'hBB,  1));
        tbl.push_back(mk(0, 1, 20, 'h100, 1, 4, 'h44, 0, 0, 0, 0,   1));
        tbl.push_back(mk(0, 1, 21, 'h101, 1, 5, 'h55, 0, 0, 0, 0,   0));
        tbl.push_back(mk(0, 1, 22, 'h102, 1, 6, 'h66, 0, 0, 0, 0,   0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 5, 1, 'h55,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 4, 1, 'h44,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 6, 1, 'h1006, 1));
        tbl.push_back(mk(0, 1, 0, 0,    1, 7, 'h01, 0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 1, 7, 'h02, 0, 0, 0,    0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 7, 1, 'h02,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 7, 1, 'h02,  1));
        tbl.push_back(mk(0, 1, 9, 'h10, 1, 9, 'h20, 0, 0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 9, 1, 'h20,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 9, 1, 'h20,  1));
        tbl.push_back(mk(0, 1, 10, 'hA0, 1, 11, 'hB1, 0, 0, 0, 0,   1));
        tbl.push_back(mk(0, 1, 12, 'hC0, 1, 13, 'hD1, 0, 0, 0, 0,   0));
        tbl.push_back(mk(1, 1, 14, 'hEE, 1, 15, 'hFF, 1, 10, 0, 0,  1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 11, 1, 'h100B, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 13, 1, 'h100D, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 10, 1, 'hA0, 1));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,    1, 14, 1, 'h100E, 1));

        v = idle_in();
        v.rst = 1'b1;
        step(v, "reset0");
        step(v, "reset1");
        check("reset data_out", data_out, '0);
        check("reset data_valid", BW'(data_valid), '0);
        check("reset wr_ready2", BW'(wr_ready2), BW'(1'b1));

        // Fill storage through port 1 so every read has defined data.
        for (int a = 0; a < 2**AW; a++) begin
            v = idle_in();
            v.we1 = 1'b1;
            v.a1  = AW'(a);
            v.d1  = BW'(32'h1000 + a);
            step(v, "init");
        end
        step(idle_in(), "init_idle");

        for (int k = 0; k < tbl.size(); k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            step(tbl[k].i, tag);
            check({tag, " data_valid"}, BW'(data_valid), BW'(tbl[k].exp_valid));
            check({tag, " wr_ready2"}, BW'(wr_ready2), BW'(tbl[k].exp_rdy2));
            if (tbl[k].exp_valid || tbl[k].i.rst) begin
                check({tag, " data_out"}, data_out, tbl[k].exp_out);
            end
        end

        // Randomized traffic over a narrow address window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.we1 = ($urandom_range(0, 2) == 0);
            v.we2 = ($urandom_range(0, 1) == 0);
            v.re  = ($urandom_range(0, 1) == 0);
            v.a1  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.a2  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.ar  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            v.d1  = BW'($urandom);
            v.d2  = BW'($urandom);
            step(v, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
